// File: rtl/point_acc_sequencer.sv
// Initiator side of the point_add handshake: accumulates a valid/ready stream of affine
// points into one frame sum, resolving identity, inverse-pair and equal-point cases locally.
module point_acc_sequencer #(
    parameter int W        = 256,
    parameter int MAX_WAIT = 1024
) (
    input  logic           clk,
    input  logic           Reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic           in_inf,
    input  logic           in_last,
    output logic           add_start,
    output logic [2*W-1:0] add_P,
    output logic [2*W-1:0] add_Q,
    input  logic           add_done,
    input  logic [2*W-1:0] add_R,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_x,
    output logic [W-1:0]   out_y,
    output logic           out_inf,
    output logic           err_double,
    output logic           err_timeout,
    input  logic           err_clr
);

    localparam int CW = $clog2(MAX_WAIT) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    localparam logic [1:0] S_ACC   = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state;
    logic [W-1:0]  acc_x;
    logic [W-1:0]  acc_y;
    logic          acc_inf;
    logic [W-1:0]  op_x;
    logic [W-1:0]  op_y;
    logic          last_pend;
    logic [CW-1:0] wait_cnt;
    logic          x_eq;
    logic          y_eq;
    logic          is_local;

    assign x_eq     = (in_x == acc_x);
    assign y_eq     = (in_y == acc_y);
    // Only a genuinely distinct, finite pair of points needs the external adder.
    assign is_local = in_inf | acc_inf | x_eq;

    assign in_ready  = (state == S_ACC);
    assign add_start = (state == S_START);
    assign add_P     = {acc_x, acc_y};
    assign add_Q     = {op_x, op_y};
    assign out_valid = (state == S_OUT);
    assign out_inf   = acc_inf;
    assign out_x     = acc_inf ? '0 : acc_x;
    assign out_y     = acc_inf ? '0 : acc_y;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_ACC;
            acc_x       <= '0;
            acc_y       <= '0;
            acc_inf     <= 1'b1;
            op_x        <= '0;
            op_y        <= '0;
            last_pend   <= 1'b0;
            wait_cnt    <= '0;
            err_double  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            // Clear comes first so that a same-cycle error event overrides it.
            if (err_clr) begin
                err_double  <= 1'b0;
                err_timeout <= 1'b0;
            end
            case (state)
                S_ACC: begin
                    if (in_valid) begin
                        if (!in_inf) begin
                            if (acc_inf) begin
                                acc_x   <= in_x;
                                acc_y   <= in_y;
                                acc_inf <= 1'b0;
                            end else if (x_eq && !y_eq) begin
                                acc_x   <= '0;
                                acc_y   <= '0;
                                acc_inf <= 1'b1;
                            end else if (x_eq) begin
                                err_double <= 1'b1;
                            end
                        end
                        if (!is_local) begin
                            op_x      <= in_x;
                            op_y      <= in_y;
                            last_pend <= in_last;
                            state     <= S_START;
                        end else if (in_last) begin
                            state <= S_OUT;
                        end
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (add_done) begin
                        acc_x   <= add_R[2*W-1:W];
                        acc_y   <= add_R[W-1:0];
                        acc_inf <= 1'b0;
                        state   <= last_pend ? S_OUT : S_ACC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        err_timeout <= 1'b1;
                        acc_x       <= '0;
                        acc_y       <= '0;
                        acc_inf     <= 1'b1;
                        state       <= last_pend ? S_OUT : S_ACC;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc_x     <= '0;
                        acc_y     <= '0;
                        acc_inf   <= 1'b1;
                        last_pend <= 1'b0;
                        state     <= S_ACC;
                    end
                end
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_point_acc_sequencer.sv
// Scoreboard bench for point_acc_sequencer with a mock adder (R = P + Q per coordinate,
// done three cycles after start); expected sums are queued per frame and popped on output.
module tb_point_acc_sequencer;

    localparam int W        = 16;
    localparam int MAX_WAIT = 16;

    logic           clk;
    logic           Reset_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_x;
    logic [W-1:0]   in_y;
    logic           in_inf;
    logic           in_last;
    logic           add_start;
    logic [2*W-1:0] add_P;
    logic [2*W-1:0] add_Q;
    logic           add_done;
    logic [2*W-1:0] add_R;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_x;
    logic [W-1:0]   out_y;
    logic           out_inf;
    logic           err_double;
    logic           err_timeout;
    logic           err_clr;

    typedef struct packed {
        logic         inf;
        logic [W-1:0] x;
        logic [W-1:0] y;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             errors = 0;
    int             start_count = 0;
    logic [2*W-1:0] last_p = '0;
    logic [2*W-1:0] last_q = '0;
    logic           mock_en = 1'b1;
    int             mock_cnt = 0;
    logic [2*W-1:0] mock_r = '0;

    point_acc_sequencer #(.W(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .Reset_n(Reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .in_inf(in_inf), .in_last(in_last),
        .add_start(add_start), .add_P(add_P), .add_Q(add_Q),
        .add_done(add_done), .add_R(add_R),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_inf(out_inf), .err_double(err_double), .err_timeout(err_timeout),
        .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mock adder keeps running across DUT reset so a stale done can arrive afterwards.
    always @(posedge clk) begin
        if (add_start && mock_en) begin
            mock_cnt <= 3;
            mock_r   <= {add_P[2*W-1:W] + add_Q[2*W-1:W], add_P[W-1:0] + add_Q[W-1:0]};
        end else if (mock_cnt > 0) begin
            mock_cnt <= mock_cnt - 1;
        end
    end
    assign add_done = (mock_cnt == 1);
    assign add_R    = mock_r;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (add_start) begin
            start_count++;
            last_p = add_P;
            last_q = add_Q;
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("out_inf", 64'(out_inf), 64'(e.inf));
                checkOutput("out_x", 64'(out_x), 64'(e.x));
                checkOutput("out_y", 64'(out_y), 64'(e.y));
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic inf, input logic last);
        int n;
        @(posedge clk);
        #1;
        in_x     = x;
        in_y     = y;
        in_inf   = inf;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 200);
        if (!in_ready) checkOutput("accept", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic pulseClear();
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int n;
        Reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_inf    = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_add_start", 64'(add_start), 64'd0);
        checkOutput("rst_errs", 64'({err_double, err_timeout}), 64'd0);
        checkOutput("rst_out_inf", 64'(out_inf), 64'd1);
        @(posedge clk);
        #1 Reset_n = 1'b1;

        // Single point frame: local path, output one cycle after accept.
        s0 = start_count;
        sb.push_back('{inf: 1'b0, x: 16'd6, y: 16'd1});
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("single_latency", 64'(out_valid), 64'd1);
        waitDrain("single_drain");
        checkOutput("single_starts", 64'(start_count - s0), 64'd0);

        // Two distinct points: one add request.
        s0 = start_count;
        sb.push_back('{inf: 1'b0, x: 16'd14, y: 16'd2});
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b0);
        applyStimulus(16'd8, 16'd1, 1'b0, 1'b1);
        waitDrain("add_drain");
        checkOutput("add_starts", 64'(start_count - s0), 64'd1);
        checkOutput("add_P", 64'(last_p), 64'({16'd6, 16'd1}));
        checkOutput("add_Q", 64'(last_q), 64'({16'd8, 16'd1}));

        // Inverse pair cancels to infinity with no add.
        s0 = start_count;
        sb.push_back('{inf: 1'b1, x: 16'd0, y: 16'd0});
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b0);
        applyStimulus(16'd6, 16'd5, 1'b0, 1'b1);
        waitDrain("inv_drain");
        checkOutput("inv_starts", 64'(start_count - s0), 64'd0);

        // Equal points: sticky doubling error, accumulator unchanged.
        sb.push_back('{inf: 1'b0, x: 16'd6, y: 16'd1});
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b0);
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b1);
        waitDrain("dbl_drain");
        checkOutput("dbl_err_set", 64'(err_double), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("dbl_err_sticky", 64'(err_double), 64'd1);
        pulseClear();
        checkOutput("dbl_err_clr", 64'(err_double), 64'd0);

        // Adder never answers: timeout after MAX_WAIT cycles in WAIT.
        mock_en = 1'b0;
        sb.push_back('{inf: 1'b1, x: 16'd0, y: 16'd0});
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b0);
        applyStimulus(16'd8, 16'd1, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("to_start", 64'(add_start), 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == MAX_WAIT) checkOutput("to_not_early", 64'(err_timeout), 64'd0);
        end while (!out_valid && n < 100);
        checkOutput("to_wait_len", 64'(n), 64'(MAX_WAIT + 1));
        checkOutput("to_err_set", 64'(err_timeout), 64'd1);
        waitDrain("to_drain");
        mock_en = 1'b1;
        pulseClear();
        checkOutput("to_err_clr", 64'(err_timeout), 64'd0);

        // Reset during WAIT; the late done must be ignored.
        applyStimulus(16'd6, 16'd1, 1'b0, 1'b0);
        applyStimulus(16'd8, 16'd1, 1'b0, 1'b1);
        @(posedge clk);
        #1 Reset_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_add_start", 64'(add_start), 64'd0);
        @(posedge clk);
        #1 Reset_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_acc_empty", 64'(out_inf), 64'd1);
        checkOutput("midrst_no_timeout", 64'(err_timeout), 64'd0);
        sb.push_back('{inf: 1'b0, x: 16'd9, y: 16'd2});
        applyStimulus(16'd9, 16'd2, 1'b0, 1'b1);
        waitDrain("midrst_drain");

        // Sink stalls for five cycles: output must hold.
        out_ready = 1'b0;
        sb.push_back('{inf: 1'b0, x: 16'd3, y: 16'd4});
        applyStimulus(16'd3, 16'd4, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 64'(out_valid), 64'd1);
            checkOutput("stall_x", 64'(out_x), 64'd3);
            checkOutput("stall_y", 64'(out_y), 64'd4);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        waitDrain("stall_drain");
        repeat (2) @(negedge clk);
        checkOutput("final_idle", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
